// File: rtl/clock_pkg.sv
// Shared definitions for the clock health blocks.
//   mon_state_e    : measurement FSM states (IDLE / ARM / MEASURE)
//   clk_status_t   : one-hot window verdict (alive / slow / fast)
//   DEF_*          : default window and threshold constants
//   classify_count : maps a window edge count onto a verdict
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic alive;
    logic slow;
    logic fast;
  } clk_status_t;

  localparam int unsigned DEF_WINDOW_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_MIN_EDGES     = 100;
  localparam int unsigned DEF_MAX_EDGES     = 140;
  localparam int unsigned DEF_LOSS_CYCLES   = 64;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Exactly one verdict bit is set for any count.
  function automatic clk_status_t classify_count(
    input logic [31:0] count,
    input logic [31:0] min_edges,
    input logic [31:0] max_edges
  );
    clk_status_t st;
    st.slow  = (count < min_edges);
    st.fast  = (count > max_edges);
    st.alive = ~st.slow & ~st.fast;
    return st;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk_in domain and emits a
// single-cycle pulse for every rising transition.
//   clk_in   : sampling clock
//   rst_in   : asynchronous active-high reset
//   async_in : asynchronous input level
//   edge_out : one-cycle pulse per synchronized rising edge
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures the rising-edge rate of mon_clk_in over fixed windows of clk_in
// cycles and flags slow, fast or lost clocks.
//   clk_in      : reference clock, all logic on its rising edge
//   rst_in      : asynchronous active-high reset
//   mon_clk_in  : monitored clock, sampled as asynchronous data
//   enable_in   : 1 = run measurements
//   edge_count  : edge count of the last completed window
//   count_valid : one-cycle pulse when edge_count / verdict update
//   clk_alive   : last window within [MIN_EDGES, MAX_EDGES]
//   too_slow    : last window below MIN_EDGES
//   too_fast    : last window above MAX_EDGES
//   loss_of_clk : no edge for LOSS_CYCLES cycles while measuring
module clock_monitor
  import clock_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned MIN_EDGES     = DEF_MIN_EDGES,
  parameter int unsigned MAX_EDGES     = DEF_MAX_EDGES,
  parameter int unsigned LOSS_CYCLES   = DEF_LOSS_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             mon_clk_in,
  input  logic             enable_in,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             clk_alive,
  output logic             too_slow,
  output logic             too_fast,
  output logic             loss_of_clk
);

  localparam int unsigned WCNT_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned GAP_W  = $clog2(LOSS_CYCLES + 1);
  localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [GAP_W-1:0]  LOSS_LAST = GAP_W'(LOSS_CYCLES);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);

  mon_state_e        state_q, state_d;
  logic              enable_q;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              count_valid_q, count_valid_d;
  logic              alive_q, alive_d;
  logic              slow_q, slow_d;
  logic              fast_q, fast_d;
  logic              loss_q, loss_d;

  logic              edge_det;
  logic              arm_done;
  logic              win_last;
  logic [CNT_W-1:0]  edge_sum;
  clk_status_t       verdict;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (mon_clk_in),
    .edge_out (edge_det)
  );

  assign arm_done = (arm_cnt_q == ARM_LAST);
  assign win_last = (win_cnt_q == WIN_LAST);

  // Saturating count including an edge landing in this cycle, so the
  // terminal-cycle edge belongs to the closing window.
  assign edge_sum = (edge_det && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1)
                                                     : edge_cnt_q;

  assign verdict = classify_count(32'(edge_sum), 32'(MIN_EDGES), 32'(MAX_EDGES));

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Arming waits on the registered enable so that the
  // first ARM cycle lands one clock after enable is sampled, while a drop
  // of enable_in leaves any state on the very next clock.
  always_comb begin
    state_d = state_q;
    if (!enable_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (enable_q) state_d = ARM;
        ARM:     if (arm_done) state_d = MEASURE;
        MEASURE: state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters and outputs. Anything not explicitly advanced falls back to
  // zero, which covers the disable path (partial window dropped, gap and
  // loss cleared) while the reported count and verdict hold.
  always_comb begin
    arm_cnt_d     = '0;
    win_cnt_d     = '0;
    edge_cnt_d    = '0;
    gap_d         = '0;
    loss_d        = 1'b0;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    alive_d       = alive_q;
    slow_d        = slow_q;
    fast_d        = fast_q;

    if (enable_in) begin
      unique case (state_q)
        ARM: begin
          arm_cnt_d = arm_done ? '0 : arm_cnt_q + ARM_W'(1);
        end
        MEASURE: begin
          if (win_last) begin
            // Next window starts with no gap cycle.
            edge_count_d  = edge_sum;
            count_valid_d = 1'b1;
            alive_d       = verdict.alive;
            slow_d        = verdict.slow;
            fast_d        = verdict.fast;
          end else begin
            win_cnt_d  = win_cnt_q + WCNT_W'(1);
            edge_cnt_d = edge_sum;
          end

          if (edge_det) begin
            gap_d  = '0;
            loss_d = 1'b0;
          end else begin
            gap_d  = (gap_q == LOSS_LAST) ? gap_q : gap_q + GAP_W'(1);
            loss_d = loss_q | (gap_q == LOSS_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      enable_q      <= 1'b0;
      arm_cnt_q     <= '0;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      gap_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      alive_q       <= 1'b0;
      slow_q        <= 1'b0;
      fast_q        <= 1'b0;
      loss_q        <= 1'b0;
    end else begin
      enable_q      <= enable_in;
      arm_cnt_q     <= arm_cnt_d;
      win_cnt_q     <= win_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      gap_q         <= gap_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      alive_q       <= alive_d;
      slow_q        <= slow_d;
      fast_q        <= fast_d;
      loss_q        <= loss_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign clk_alive   = alive_q;
  assign too_slow    = slow_q;
  assign too_fast    = fast_q;
  assign loss_of_clk = loss_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: two instances (CNT_W=16 and CNT_W=4)
// share all stimulus; the narrow one exposes edge-counter saturation.
module tb_clock_monitor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mon_clk_in;
  logic        enable_in;

  logic [15:0] edge_count;
  logic        count_valid, clk_alive, too_slow, too_fast, loss_of_clk;
  logic [3:0]  edge_count4;
  logic        count_valid4, clk_alive4, too_slow4, too_fast4, loss_of_clk4;

  int checks = 0;
  int errors = 0;

  int mon_period = 10;
  bit mon_run    = 1'b0;
  int phase      = 0;

  always #5 clk_in = ~clk_in;

  clock_monitor #(
    .WINDOW_CYCLES (100),
    .CNT_W         (16),
    .MIN_EDGES     (8),
    .MAX_EDGES     (12),
    .LOSS_CYCLES   (20),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .mon_clk_in  (mon_clk_in),
    .enable_in   (enable_in),
    .edge_count  (edge_count),
    .count_valid (count_valid),
    .clk_alive   (clk_alive),
    .too_slow    (too_slow),
    .too_fast    (too_fast),
    .loss_of_clk (loss_of_clk)
  );

  clock_monitor #(
    .WINDOW_CYCLES (100),
    .CNT_W         (4),
    .MIN_EDGES     (8),
    .MAX_EDGES     (12),
    .LOSS_CYCLES   (20),
    .SYNC_STAGES   (2)
  ) dut4 (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .mon_clk_in  (mon_clk_in),
    .enable_in   (enable_in),
    .edge_count  (edge_count4),
    .count_valid (count_valid4),
    .clk_alive   (clk_alive4),
    .too_slow    (too_slow4),
    .too_fast    (too_fast4),
    .loss_of_clk (loss_of_clk4)
  );

  // Monitored clock, updated on clk_in falling edges: high for period/2
  // cycles, low for the rest; a restart always begins with a rising edge.
  initial begin
    mon_clk_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!mon_run) begin
        mon_clk_in = 1'b0;
        phase      = 0;
      end else begin
        mon_clk_in = (phase < mon_period / 2);
        phase      = (phase + 1 >= mon_period) ? 0 : phase + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk_in);
    #1;
  endtask

  // Counts rising clk_in edges (sampled #1 after) until the selected
  // condition holds; -1 if the budget runs out.
  // sel 0: count_valid, 1: loss_of_clk high, 2: loss_of_clk low
  task automatic wait_for(input int sel, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk_in);
      #1;
      n++;
      if ((sel == 0 && count_valid) || (sel == 1 && loss_of_clk) ||
          (sel == 2 && !loss_of_clk))
        return;
    end
    n = -1;
  endtask

  task automatic chk_window(input string tag, input int cnt, input int cnt4,
                            input logic a, input logic s, input logic f);
    chk({tag, "_count"}, 32'(edge_count), 32'(cnt));
    chk({tag, "_alive"}, 32'(clk_alive), 32'(a));
    chk({tag, "_slow"},  32'(too_slow),  32'(s));
    chk({tag, "_fast"},  32'(too_fast),  32'(f));
    chk({tag, "_count4"}, 32'(edge_count4), 32'(cnt4));
    chk({tag, "_fast4"},  32'(too_fast4),   32'(f));
    chk({tag, "_cv4"},    32'(count_valid4), 32'd1);
  endtask

  initial begin
    int  n;
    int  seen;
    bit  found;
    logic prev;

    rst_in    = 1'b1;
    enable_in = 1'b0;
    mon_run   = 1'b1;
    repeat (5) at_neg();

    // Reset state
    chk("rst_count", 32'(edge_count), 32'd0);
    chk("rst_cv",    32'(count_valid), 32'd0);
    chk("rst_flags", 32'({clk_alive, too_slow, too_fast, loss_of_clk}), 32'd0);
    chk("rst_count4", 32'(edge_count4), 32'd0);

    rst_in = 1'b0;
    repeat (3) at_neg();

    // 1: period 10, first verdict at edge 104 after the enable sample
    //    (edges 0..104 = 105 rising edges counted)
    enable_in = 1'b1;
    wait_for(0, 400, n);
    chk("first_latency", 32'(n), 32'd105);
    chk_window("p10_w1", 10, 10, 1'b1, 1'b0, 1'b0);
    @(posedge clk_in);
    #1;
    chk("cv_one_cycle", 32'(count_valid), 32'd0);
    wait_for(0, 200, n);
    chk("p10_period", 32'(n), 32'd99);
    chk_window("p10_w2", 10, 10, 1'b1, 1'b0, 1'b0);

    // 2: period 20 -> 5 edges, period 5 -> 20 edges (narrow copy saturates)
    at_neg();
    mon_period = 20;
    wait_for(0, 200, n);
    chk("p20_trans_period", 32'(n), 32'd100);
    wait_for(0, 200, n);
    chk("p20_period", 32'(n), 32'd100);
    chk_window("p20", 5, 5, 1'b0, 1'b1, 1'b0);

    at_neg();
    mon_period = 5;
    wait_for(0, 200, n);
    chk("p5_trans_period", 32'(n), 32'd100);
    wait_for(0, 200, n);
    chk("p5_period", 32'(n), 32'd100);
    chk_window("p5", 20, 15, 1'b0, 1'b0, 1'b1);

    // 6: period 4 -> 25 edges; 4-bit counter pins at 15
    at_neg();
    mon_period = 4;
    wait_for(0, 200, n);
    chk("p4_trans_period", 32'(n), 32'd100);
    wait_for(0, 200, n);
    chk("p4_period", 32'(n), 32'd100);
    chk_window("p4", 25, 15, 1'b0, 1'b0, 1'b1);

    // 3: stop right after a rising edge of mon_clk_in (one high cycle).
    //    Sampled at edge k, detected at k+2, gap reaches 20 at k+22,
    //    loss visible after k+23 -> 24 rising edges from here.
    at_neg();
    prev  = mon_clk_in;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      at_neg();
      if (mon_clk_in && !prev) found = 1'b1;
      else prev = mon_clk_in;
    end
    mon_run = 1'b0;
    chk("loss_pre", 32'(loss_of_clk), 32'd0);
    wait_for(1, 60, n);
    chk("loss_rise", 32'(n), 32'd24);
    wait_for(0, 200, n);
    chk("stop_partial_window", 32'(n >= 1 && n <= 100), 32'd1);
    wait_for(0, 200, n);
    chk("stop_period", 32'(n), 32'd100);
    chk_window("stopped", 0, 0, 1'b0, 1'b1, 1'b0);
    chk("loss_held", 32'(loss_of_clk), 32'd1);
    chk("loss_held4", 32'(loss_of_clk4), 32'd1);

    // Restart: rise at next falling edge, sampled one edge later,
    // detected two after that, loss clears on that edge -> 4 edges.
    mon_period = 10;
    at_neg();
    mon_run = 1'b1;
    wait_for(2, 20, n);
    chk("loss_clear", 32'(n), 32'd4);
    wait_for(0, 200, n);
    chk("restart_partial_window", 32'(n >= 1 && n <= 100), 32'd1);
    wait_for(0, 200, n);
    chk("restart_period", 32'(n), 32'd100);
    chk_window("restart", 10, 10, 1'b1, 1'b0, 1'b0);

    // 4: drop enable at window cycle 50, no verdict while disabled
    repeat (50) @(posedge clk_in);
    at_neg();
    enable_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk_in);
      #1;
      if (count_valid) seen++;
    end
    chk("dis_no_cv", 32'(seen), 32'd0);
    chk("dis_count_hold", 32'(edge_count), 32'd10);
    chk("dis_alive_hold", 32'(clk_alive), 32'd1);
    chk("dis_loss", 32'(loss_of_clk), 32'd0);
    at_neg();
    enable_in = 1'b1;
    wait_for(0, 400, n);
    chk("reen_latency", 32'(n), 32'd105);
    chk_window("reen", 10, 10, 1'b1, 1'b0, 1'b0);

    // 5: asynchronous reset between clock edges, mid-window
    repeat (30) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst_count", 32'(edge_count), 32'd0);
    chk("arst_flags", 32'({count_valid, clk_alive, too_slow, too_fast, loss_of_clk}), 32'd0);
    chk("arst_count4", 32'(edge_count4), 32'd0);
    at_neg();
    rst_in = 1'b0;
    wait_for(0, 400, n);
    chk("post_rst_latency", 32'(n), 32'd105);
    chk_window("post_rst", 10, 10, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
